// File: rtl/vector_recorder.sv
// Vector recorder: samples {a,b,c,y} once per period at mid-period into a small buffer,
// then drains the buffer through a valid/ready readout port and pulses done.
module vector_recorder #(
   parameter int PERIOD_CYCLES = 20,
   parameter int DEPTH         = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     a,
   input  logic                     b,
   input  logic                     c,
   input  logic                     y,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [3:0]               out_data,
   output logic [$clog2(DEPTH)-1:0] out_index,
   output logic                     busy,
   output logic                     done
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(PERIOD_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(PERIOD_CYCLES / 2 - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, FINISH} state_t;

   state_t        state;
   logic [1:0]    rst_sync;
   logic          run_ok;
   logic [CW-1:0] period_cnt;
   logic [IW-1:0] wr_idx;
   logic          sample_now;
   logic [3:0]    buffer [DEPTH];

   // Reset release is retimed so a start request is only honoured once the release is clean.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign run_ok     = rst_sync[1];
   assign sample_now = (state == CAPTURE) && (period_cnt == CNT_MID);

   // Buffer has no reset: its contents survive runs and resets until overwritten.
   always_ff @(posedge clk) begin
      if (sample_now) begin
         buffer[wr_idx] <= {a, b, c, y};
      end
   end

   // out_index doubles as the read pointer; it is only non-zero while draining.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         period_cnt <= '0;
         wr_idx     <= '0;
         out_valid  <= 1'b0;
         out_data   <= 4'h0;
         out_index  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start && run_ok) begin
                  state      <= CAPTURE;
                  period_cnt <= '0;
                  wr_idx     <= '0;
                  busy       <= 1'b1;
               end
            end
            CAPTURE: begin
               period_cnt <= (period_cnt == CNT_LAST) ? '0 : period_cnt + CW'(1);
               if (sample_now) begin
                  wr_idx <= wr_idx + IW'(1);
                  if (wr_idx == IDX_LAST) begin
                     state     <= DRAIN;
                     out_valid <= 1'b1;
                     out_data  <= buffer[0];
                     out_index <= '0;
                  end
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (out_index == IDX_LAST) begin
                     state     <= FINISH;
                     out_valid <= 1'b0;
                     out_data  <= 4'h0;
                     out_index <= '0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     out_data  <= buffer[out_index + IW'(1)];
                     out_index <= out_index + IW'(1);
                  end
               end
            end
            FINISH: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vector_recorder.sv
// Self-checking bench for vector_recorder: cycle-level behavioural model for a 4/4 instance
// plus directed literal checks, and a directed run of a default-parameter instance.
module tb_vector_recorder;

   localparam int P = 4;
   localparam int D = 4;

   logic       clk;
   logic       rst_n;
   logic       start, a, b, c, y, out_ready;
   logic       out_valid, busy, done;
   logic [3:0] out_data;
   logic [1:0] out_index;

   logic       d_start, d_a, d_b, d_c, d_y, d_ready;
   logic       d_valid, d_busy, d_done;
   logic [3:0] d_data;
   logic [3:0] d_index;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   bit         m_cap, m_drain, m_fin;
   int         m_elapsed, m_wr, m_rd;
   logic [3:0] m_mem [D];

   logic [3:0] got_data [$];
   int         got_idx  [$];
   int         got_cyc  [$];
   int         done_count;

   vector_recorder #(.PERIOD_CYCLES(P), .DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c(c), .y(y),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .busy(busy), .done(done)
   );

   vector_recorder dut_dflt (
      .clk(clk), .rst_n(rst_n), .start(d_start), .a(d_a), .b(d_b), .c(d_c), .y(d_y),
      .out_valid(d_valid), .out_ready(d_ready), .out_data(d_data),
      .out_index(d_index), .busy(d_busy), .done(d_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void check(string name, int actual, int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
      end
   endfunction

   always @(posedge clk) cyc++;

   // Model: a run is a count of edges since the start edge; a sample is due every
   // P edges offset by P/2, and the drain presents stored words in order.
   always @(posedge clk) begin
      if (!rst_n) begin
         m_cap = 0; m_drain = 0; m_fin = 0;
         m_elapsed = 0; m_wr = 0; m_rd = 0;
      end else if (m_fin) begin
         m_fin = 0;
      end else if (m_drain) begin
         if (out_ready) begin
            m_rd++;
            if (m_rd == D) begin
               m_drain = 0; m_fin = 1; m_rd = 0;
            end
         end
      end else if (m_cap) begin
         m_elapsed++;
         if (m_elapsed % P == P / 2) begin
            m_mem[m_wr] = {a, b, c, y};
            m_wr++;
            if (m_wr == D) begin
               m_cap = 0; m_drain = 1; m_rd = 0;
            end
         end
      end else if (start) begin
         m_cap = 1; m_elapsed = 0; m_wr = 0;
      end
   end

   always @(posedge clk) begin
      #1;
      check("cyc_valid", out_valid, m_drain);
      check("cyc_data",  out_data,  m_drain ? int'(m_mem[m_rd]) : 0);
      check("cyc_index", out_index, m_drain ? m_rd : 0);
      check("cyc_busy",  busy,      m_cap | m_drain);
      check("cyc_done",  done,      m_fin);
   end

   always @(negedge clk) begin
      #1;
      if (out_valid && out_ready) begin
         got_data.push_back(out_data);
         got_idx.push_back(out_index);
         got_cyc.push_back(cyc);
      end
      if (done) done_count++;
   end

   task automatic clearMon();
      got_data.delete();
      got_idx.delete();
      got_cyc.delete();
      done_count = 0;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      start = 1'b0;
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_data",  out_data,  0);
      check("rst_index", out_index, 0);
      check("rst_busy",  busy,      0);
      check("rst_done",  done,      0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [3:0] w0, input logic [3:0] w1, input logic [3:0] w2,
                                input logic [3:0] w3, input bit junk, input bit poke, input int lastK);
      logic [3:0] w [4];
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      for (int k = 0; k <= lastK; k++) begin
         @(negedge clk);
         start = (k == 0) || (poke && k == 7);
         if (junk && (k % 4) != 2) begin
            {a, b, c, y} = 4'($urandom_range(15, 0));
         end else begin
            {a, b, c, y} = w[k / 4];
         end
      end
   endtask

   task automatic drainRun(input int stallLo, input int stallHi, input int resetAt, input bit poke);
      for (int c2 = 0; c2 < 16; c2++) begin
         if (c2 == resetAt) begin
            doReset();
            break;
         end
         @(negedge clk);
         out_ready = !(c2 >= stallLo && c2 < stallHi);
         start     = poke && (c2 == 1 || done);
      end
      @(negedge clk);
      out_ready = 1'b0;
      start     = 1'b0;
   endtask

   task automatic checkOutput(input logic [3:0] w0, input logic [3:0] w1, input logic [3:0] w2,
                              input logic [3:0] w3, input bit consecutive, input string tag);
      logic [3:0] w [4];
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      check({tag, "_count"}, got_data.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check({tag, "_model_mem"}, m_mem[i], w[i]);
         if (i < got_data.size()) begin
            check({tag, "_word"},  got_data[i], w[i]);
            check({tag, "_index"}, got_idx[i],  i);
            if (consecutive) check({tag, "_spacing"}, got_cyc[i] - got_cyc[0], i);
         end
      end
      check({tag, "_done_pulses"}, done_count, 1);
      check({tag, "_busy_after"},  busy, 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; {a, b, c, y} = 4'h0; out_ready = 1'b0;
      d_start = 1'b0; {d_a, d_b, d_c, d_y} = 4'h0; d_ready = 1'b1;
      doReset();

      clearMon();
      applyStimulus(4'h3, 4'h5, 4'h9, 4'hE, 1'b0, 1'b0, 14);
      drainRun(99, 99, -1, 1'b0);
      checkOutput(4'h3, 4'h5, 4'h9, 4'hE, 1'b1, "basic");

      clearMon();
      applyStimulus(4'hA, 4'h6, 4'h1, 4'hF, 1'b1, 1'b0, 14);
      drainRun(99, 99, -1, 1'b0);
      checkOutput(4'hA, 4'h6, 4'h1, 4'hF, 1'b1, "midsample");

      clearMon();
      applyStimulus(4'h7, 4'h2, 4'hC, 4'h4, 1'b0, 1'b0, 14);
      drainRun(2, 7, -1, 1'b0);
      checkOutput(4'h7, 4'h2, 4'hC, 4'h4, 1'b0, "backpressure");

      clearMon();
      applyStimulus(4'h8, 4'hB, 4'h0, 4'hD, 1'b0, 1'b1, 14);
      drainRun(99, 99, -1, 1'b1);
      checkOutput(4'h8, 4'hB, 4'h0, 4'hD, 1'b1, "start_ignored");
      clearMon();
      applyStimulus(4'h1, 4'h2, 4'h4, 4'h8, 1'b0, 1'b0, 14);
      drainRun(99, 99, -1, 1'b0);
      checkOutput(4'h1, 4'h2, 4'h4, 4'h8, 1'b1, "second_start");

      clearMon();
      applyStimulus(4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 8);
      doReset();
      check("capture_abort_done", done_count, 0);
      clearMon();
      applyStimulus(4'h5, 4'hA, 4'h5, 4'hA, 1'b0, 1'b0, 14);
      drainRun(99, 99, -1, 1'b0);
      checkOutput(4'h5, 4'hA, 4'h5, 4'hA, 1'b1, "after_capture_reset");

      clearMon();
      applyStimulus(4'hC, 4'h3, 4'h6, 4'h9, 1'b0, 1'b0, 14);
      drainRun(99, 99, 1, 1'b0);
      check("drain_abort_done", done_count, 0);
      check("drain_abort_words", got_data.size(), 1);
      clearMon();
      applyStimulus(4'hE, 4'hD, 4'hB, 4'h7, 1'b0, 1'b0, 14);
      drainRun(99, 99, -1, 1'b0);
      checkOutput(4'hE, 4'hD, 4'hB, 4'h7, 1'b1, "after_drain_reset");

      // Default instance: word n is held through period n, so sample n must read n.
      for (int k = 0; k <= 310; k++) begin
         @(negedge clk);
         if (k == 310) check("dflt_valid_before_310", d_valid, 0);
         d_start = (k == 0);
         {d_a, d_b, d_c, d_y} = 4'(k / 20);
      end
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("dflt_valid", d_valid, 1);
         check("dflt_index", d_index, i);
         check("dflt_data",  d_data,  i);
         check("dflt_done_early", d_done, 0);
      end
      @(negedge clk);
      check("dflt_done", d_done, 1);
      check("dflt_valid_after", d_valid, 0);
      check("dflt_busy_after", d_busy, 0);
      @(negedge clk);
      check("dflt_done_once", d_done, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
